swing_detector: RTL and testbench
=================================

Name: swing_detector

Overview:
- Consumes the 16-bit signed Z-axis angular velocity word from the IMU packet parser, which updates only on valid packets and has no strobe.
- Samples that word at a fixed internal rate and detects a racket swing: magnitude above a threshold for a minimum time, then falling below a release level.
- On each swing, emits a one-cycle event with peak magnitude and direction. Downstream game/hit logic uses these events.

Parameters:
- SAMPLE_DIV, 1000000, clk cycles per sample tick (100 Hz at 100 MHz; must be >= 4).
- TRIG_THR, 16'd8192, magnitude at or above which a swing candidate starts (about 500 deg/s at ±2000 deg/s full scale).
- REL_THR, 16'd4096, magnitude below which a candidate ends (hysteresis; REL_THR <= TRIG_THR).
- MIN_SAMPLES, 3, minimum consecutive samples at or above REL_THR, starting with the trigger sample, for a valid swing.
- MAX_SAMPLES, 100, active-length limit; exceeding it aborts the candidate.
- COOLDOWN_SAMPLES, 20, samples ignored after a swing or abort.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- angular_v, input, 16, signed two's-complement Z angular velocity, held between packets.
- swing, output, 1, one-cycle pulse per detected swing.
- swing_peak, output, 16, peak magnitude of the last swing (unsigned, 0..32767), held until the next swing.
- swing_dir, output, 1, sign at peak: 0 positive, 1 negative; held with swing_peak.
- swing_count, output, 8, number of detected swings, wraps 255 -> 0.
- active, output, 1, high while in state ACTIVE.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, divider 0, sample register 0, all counters 0. Reset mid-swing discards the candidate with no pulse.
- Divider:
  - counts 0..SAMPLE_DIV-1, free-running.
  - tick asserted for the one cycle where count == SAMPLE_DIV-1.
  - On a tick cycle T, angular_v is registered into smp.
  - The FSM steps at T+1 using smp. Registered outputs change at T+2 (visible the cycle after the step).
- Magnitude: mag = |smp|, 16-bit unsigned; -32768 saturates to 32767. The sign of smp is tracked with mag.
- FSM (steps only at T+1):
  - IDLE: if mag >= TRIG_THR, go to ACTIVE with len=1, peak=mag, pdir=sign.
  - ACTIVE, mag >= REL_THR:
    - len++.
    - If mag > peak, update peak and pdir. Equal magnitude keeps the earlier peak.
    - If len would exceed MAX_SAMPLES, go to COOLDOWN with no pulse.
  - ACTIVE, mag < REL_THR:
    - If len >= MIN_SAMPLES: swing=1 for one cycle, swing_peak<=peak, swing_dir<=pdir, swing_count++. Go to COOLDOWN.
    - Otherwise: go to IDLE silently (glitch rejection).
  - COOLDOWN: count cd on each step; after COOLDOWN_SAMPLES steps, go to IDLE. Samples in COOLDOWN are ignored, even above TRIG_THR.
  - From IDLE, a new trigger can be evaluated on the first step after re-entry.
- Sign reversal inside ACTIVE is not a new swing. The direction is taken at the peak.
- The held angular_v is resampled every tick. A stale value is valid input; a parser stuck high hits the MAX_SAMPLES abort.
- swing and active are registered. swing is never high for two consecutive cycles.

Optional Feature:
- SWING_FILTER_EN defined:
  - smp is replaced by a 4-tap moving average of the last four sampled angular_v values. The sum is 18-bit signed, arithmetic shift right by 2.
  - Taps reset to 0.
  - Adds no clk latency beyond the tick register: the average is updated at T, and the FSM uses it at T+1.
- Not defined: smp is the raw sampled angular_v.

Test Plan (SAMPLE_DIV=4, MIN_SAMPLES=3, MAX_SAMPLES=8, COOLDOWN_SAMPLES=2, filter off unless stated):
- Basic swing: samples 0, 9000, 12000, 10000, 1000. Expect swing pulse 2 clk after the 1000 sample's tick, swing_peak=12000, swing_dir=0, swing_count=1, active high for 3 sample periods.
- Negative direction with saturation: samples -8192, -32768, -9000, 0. Expect swing_peak=32767, swing_dir=1.
- Glitch: samples 9000, 9000, 100 (len=2). Expect no pulse, return to IDLE, swing_count unchanged.
- Hysteresis and cooldown:
  - Samples 9000, 5000, 5000, 0 → pulse.
  - Next two samples 20000, 20000 (in COOLDOWN) → ignored.
  - Then 9000, 9000, 9000, 0 → second pulse, swing_count=2.
- Stuck sensor: hold 15000 for 12 samples. Expect no pulse, active drops after the 9th sample step, COOLDOWN entered. Holding 15000 re-triggers after the cooldown.
- Reset mid-ACTIVE:
  - Assert rst for 1 cycle after 2 high samples → all outputs 0 the next cycle.
  - Then 0, 0 → no pulse.
  - With SWING_FILTER_EN, a single 32000 sample yields smp=8000 (below TRIG_THR) → no trigger.

Source files
------------

// File: rtl/swing_detector.sv
// -----------------------------------------------------------------------------
// swing_detector
//
// Detects a racket swing from the Z-axis angular velocity word published by
// the IMU packet parser. The word has no strobe and only changes on valid
// packets, so it is resampled on a fixed internal tick.
//
// A swing is reported when the magnitude rises to TRIG_THR or above and stays
// at or above REL_THR for at least MIN_SAMPLES consecutive samples before it
// drops below REL_THR. The trigger sample counts as one of those samples. A
// candidate that lasts longer than MAX_SAMPLES is aborted with no event. After
// a swing or an abort, COOLDOWN_SAMPLES samples are ignored.
//
// Timing: the tick is high on cycle T, where angular_v is captured into the
// sample register. The FSM steps on T+1, and the registered outputs show the
// result from T+2.
//
// Optional build macro:
//   SWING_FILTER_EN - the sample register holds a 4-tap moving average of the
//                     last four captured angular_v values instead of the raw
//                     word. It adds no extra clock latency.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   angular_v    in   [15:0] signed Z angular velocity, held between packets
//   swing        out  one-cycle pulse per detected swing
//   swing_peak   out  [15:0] peak magnitude of the last swing (0..32767)
//   swing_dir    out  sign at the peak (0 positive, 1 negative)
//   swing_count  out  [7:0] number of detected swings, wraps at 256
//   active       out  high while a swing candidate is being tracked
// -----------------------------------------------------------------------------
module swing_detector #(
    parameter int unsigned SAMPLE_DIV       = 1000000,
    parameter logic [15:0] TRIG_THR         = 16'd8192,
    parameter logic [15:0] REL_THR          = 16'd4096,
    parameter int unsigned MIN_SAMPLES      = 3,
    parameter int unsigned MAX_SAMPLES      = 100,
    parameter int unsigned COOLDOWN_SAMPLES = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] angular_v,
    output logic               swing,
    output logic [15:0]        swing_peak,
    output logic               swing_dir,
    output logic [7:0]         swing_count,
    output logic               active
);

    // Counter widths. Each width is large enough for its limit, so the
    // comparisons below never wrap.
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int LEN_W = $clog2(MAX_SAMPLES + 2);
    localparam int CD_W  = $clog2(COOLDOWN_SAMPLES + 2);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_SAMPLES);
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_SAMPLES);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [CD_W-1:0]  CD_LIM   = CD_W'(COOLDOWN_SAMPLES);
    localparam logic [CD_W-1:0]  CD_ONE   = CD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_COOL   = 2'd2
    } state_t;

    // Returns |v| as unsigned. -32768 saturates to 32767 so the result
    // always fits the 0..32767 range of swing_peak.
    function automatic logic [15:0] abs_sat(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'h8000) begin
            r = 16'h7FFF;
        end else if (v[15]) begin
            r = (~v) + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Sample divider and sample register
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0]   div_cnt_r;
    logic               tick_s;
    logic               step_r;
    logic signed [15:0] smp_r;
    logic signed [15:0] smp_next_s;

    assign tick_s = (div_cnt_r == DIV_LAST);

`ifdef SWING_FILTER_EN
    // The three previous captures. The sum also includes the current word,
    // so the average covers four samples and is ready on the tick edge.
    logic signed [15:0] tap0_r;
    logic signed [15:0] tap1_r;
    logic signed [15:0] tap2_r;
    logic signed [17:0] sum_s;
    logic [1:0]         frac_unused_s;

    assign sum_s = {{2{angular_v[15]}}, angular_v} + {{2{tap0_r[15]}}, tap0_r}
                 + {{2{tap1_r[15]}}, tap1_r}       + {{2{tap2_r[15]}}, tap2_r};
    // Bits [17:2] are the arithmetic shift right by 2, truncated to 16 bits.
    // The value always fits, because the mean of four 16-bit words is a
    // 16-bit word.
    assign smp_next_s    = sum_s[17:2];
    assign frac_unused_s = sum_s[1:0];

    // Moving-average tap history, shifted once per tick
    always_ff @(posedge clk) begin
        if (rst) begin
            tap0_r <= 16'sd0;
            tap1_r <= 16'sd0;
            tap2_r <= 16'sd0;
        end else if (tick_s) begin
            tap0_r <= angular_v;
            tap1_r <= tap0_r;
            tap2_r <= tap1_r;
        end else begin
            tap0_r <= tap0_r;
            tap1_r <= tap1_r;
            tap2_r <= tap2_r;
        end
    end
`else
    assign smp_next_s = angular_v;
`endif

    // Free-running divider, delayed tick (FSM step enable) and sample capture
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
            step_r    <= 1'b0;
            smp_r     <= 16'sd0;
        end else begin
            if (tick_s) begin
                div_cnt_r <= '0;
                smp_r     <= smp_next_s;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
                smp_r     <= smp_r;
            end
            step_r <= tick_s;
        end
    end

    // ---------------------------------------------------------------------
    // Magnitude / sign of the current sample
    // ---------------------------------------------------------------------
    logic [15:0] mag_s;
    logic        sign_s;
    logic        trig_s;
    logic        above_rel_s;

    assign mag_s       = abs_sat(smp_r);
    assign sign_s      = smp_r[15];
    assign trig_s      = (mag_s >= TRIG_THR);
    assign above_rel_s = (mag_s >= REL_THR);

    // ---------------------------------------------------------------------
    // FSM and datapath state
    // ---------------------------------------------------------------------
    state_t           state_r;
    state_t           state_next_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_next_s;
    logic [15:0]      peak_r;
    logic [15:0]      peak_next_s;
    logic             pdir_r;
    logic             pdir_next_s;
    logic [CD_W-1:0]  cd_r;
    logic [CD_W-1:0]  cd_next_s;
    logic [CD_W-1:0]  cd_inc_s;
    logic             cd_done_s;

    logic             swing_next_s;
    logic [15:0]      swing_peak_next_s;
    logic             swing_dir_next_s;
    logic [7:0]       swing_count_next_s;
    logic             active_next_s;

    assign cd_inc_s  = cd_r + CD_ONE;
    assign cd_done_s = (cd_inc_s >= CD_LIM);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode. Transitions happen only on the step after a tick.
    always_comb begin
        state_next_s = state_r;
        if (step_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (trig_s) begin
                        state_next_s = ST_ACTIVE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (above_rel_s) begin
                        // Another sample would push the length past the limit.
                        if (len_r >= MAX_LEN) begin
                            state_next_s = ST_COOL;
                        end else begin
                            state_next_s = ST_ACTIVE;
                        end
                    end else begin
                        // Release: a long enough run is a swing, a short run
                        // is a glitch.
                        if (len_r >= MIN_LEN) begin
                            state_next_s = ST_COOL;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end
                end
                ST_COOL: begin
                    if (cd_done_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_COOL;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Datapath and output decode for each state on a step
    always_comb begin
        len_next_s         = len_r;
        peak_next_s        = peak_r;
        pdir_next_s        = pdir_r;
        cd_next_s          = cd_r;
        swing_next_s       = 1'b0;
        swing_peak_next_s  = swing_peak;
        swing_dir_next_s   = swing_dir;
        swing_count_next_s = swing_count;
        if (step_r) begin
            case (state_r)
                ST_IDLE: begin
                    cd_next_s = '0;
                    if (trig_s) begin
                        len_next_s  = LEN_ONE;
                        peak_next_s = mag_s;
                        pdir_next_s = sign_s;
                    end else begin
                        len_next_s  = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (above_rel_s) begin
                        if (len_r >= MAX_LEN) begin
                            len_next_s = '0;
                            cd_next_s  = '0;
                        end else begin
                            len_next_s = len_r + LEN_ONE;
                            // A strict compare keeps the earlier peak when
                            // two magnitudes are equal.
                            if (mag_s > peak_r) begin
                                peak_next_s = mag_s;
                                pdir_next_s = sign_s;
                            end else begin
                                peak_next_s = peak_r;
                                pdir_next_s = pdir_r;
                            end
                        end
                    end else begin
                        len_next_s = '0;
                        cd_next_s  = '0;
                        if (len_r >= MIN_LEN) begin
                            swing_next_s       = 1'b1;
                            swing_peak_next_s  = peak_r;
                            swing_dir_next_s   = pdir_r;
                            swing_count_next_s = swing_count + 8'd1;
                        end else begin
                            swing_next_s       = 1'b0;
                        end
                    end
                end
                ST_COOL: begin
                    if (cd_done_s) begin
                        cd_next_s = '0;
                    end else begin
                        cd_next_s = cd_inc_s;
                    end
                end
                default: begin
                    len_next_s = '0;
                    cd_next_s  = '0;
                end
            endcase
        end else begin
            swing_next_s = 1'b0;
        end
    end

    assign active_next_s = (state_next_s == ST_ACTIVE);

    // Datapath and registered output update
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r       <= '0;
            peak_r      <= 16'd0;
            pdir_r      <= 1'b0;
            cd_r        <= '0;
            swing       <= 1'b0;
            swing_peak  <= 16'd0;
            swing_dir   <= 1'b0;
            swing_count <= 8'd0;
            active      <= 1'b0;
        end else begin
            len_r       <= len_next_s;
            peak_r      <= peak_next_s;
            pdir_r      <= pdir_next_s;
            cd_r        <= cd_next_s;
            swing       <= swing_next_s;
            swing_peak  <= swing_peak_next_s;
            swing_dir   <= swing_dir_next_s;
            swing_count <= swing_count_next_s;
            active      <= active_next_s;
        end
    end

endmodule

// File: tb/tb_swing_detector.sv
// -----------------------------------------------------------------------------
// tb_swing_detector
//
// Self-checking bench for swing_detector with a short sample period. The
// reference model works one sample at a time. It keeps the magnitudes of the
// current candidate in a queue, finds the peak by scanning that queue when the
// candidate releases, and counts down the cooldown samples.
// -----------------------------------------------------------------------------
module tb_swing_detector;

    localparam int DIV  = 4;
    localparam int MINS = 3;
    localparam int MAXS = 8;
    localparam int CDS  = 2;
    localparam int TRIG = 8192;
    localparam int REL  = 4096;

    logic               clk;
    logic               rst;
    logic signed [15:0] angular_v;
    logic               swing;
    logic [15:0]        swing_peak;
    logic               swing_dir;
    logic [7:0]         swing_count;
    logic               active;

    swing_detector #(
        .SAMPLE_DIV       (DIV),
        .TRIG_THR         (16'd8192),
        .REL_THR          (16'd4096),
        .MIN_SAMPLES      (MINS),
        .MAX_SAMPLES      (MAXS),
        .COOLDOWN_SAMPLES (CDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .angular_v   (angular_v),
        .swing       (swing),
        .swing_peak  (swing_peak),
        .swing_dir   (swing_dir),
        .swing_count (swing_count),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int run_mag[$];
    bit run_neg[$];
    int cool_left;
    bit exp_swing;
    int exp_peak;
    bit exp_dir;
    int exp_count;
    int hist[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mag_of(input int v);
        if (v == -32768) return 32767;
        else if (v < 0) return -v;
        else return v;
    endfunction

    task automatic model_reset();
        run_mag.delete();
        run_neg.delete();
        cool_left = 0;
        exp_swing = 1'b0;
        exp_peak  = 0;
        exp_dir   = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 3; i++) hist[i] = 0;
    endtask

    // Apply the detection rules to one sample value
    task automatic model_step(input int v);
        int s;
        int m;
        int pk;
        bit pd;
`ifdef SWING_FILTER_EN
        s = (v + hist[0] + hist[1] + hist[2]) >>> 2;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = v;
`else
        s = v;
`endif
        m = mag_of(s);
        exp_swing = 1'b0;
        if (cool_left > 0) begin
            cool_left--;
        end else if (run_mag.size() == 0) begin
            if (m >= TRIG) begin
                run_mag.push_back(m);
                run_neg.push_back(s < 0);
            end
        end else if (m >= REL) begin
            run_mag.push_back(m);
            run_neg.push_back(s < 0);
            if (run_mag.size() > MAXS) begin
                run_mag.delete();
                run_neg.delete();
                cool_left = CDS;
            end
        end else begin
            if (run_mag.size() >= MINS) begin
                pk = run_mag[0];
                pd = run_neg[0];
                for (int i = 1; i < run_mag.size(); i++) begin
                    if (run_mag[i] > pk) begin
                        pk = run_mag[i];
                        pd = run_neg[i];
                    end
                end
                exp_swing = 1'b1;
                exp_peak  = pk;
                exp_dir   = pd;
                exp_count = (exp_count + 1) % 256;
                cool_left = CDS;
            end
            run_mag.delete();
            run_neg.delete();
        end
    endtask

    task automatic check_outputs(input bit first);
        check("swing",       {31'd0, swing},       first ? {31'd0, exp_swing} : 32'd0);
        check("active",      {31'd0, active},      (run_mag.size() != 0) ? 32'd1 : 32'd0);
        check("swing_peak",  {16'd0, swing_peak},  exp_peak);
        check("swing_dir",   {31'd0, swing_dir},   {31'd0, exp_dir});
        check("swing_count", {24'd0, swing_count}, exp_count);
    endtask

    // One sample period, starting at a negedge just after a capture edge.
    // The first check shows the FSM step for the previous sample.
    task automatic run_sample(input int v);
        angular_v = 16'(v);
        for (int c = 0; c < DIV; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs(c == 0);
        end
        model_step(v);
    endtask

    // One-cycle reset. It starts and ends on a negedge, which keeps the
    // sample periods aligned with the DUT divider.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_swing",  {31'd0, swing},       32'd0);
        check("rst_active", {31'd0, active},      32'd0);
        check("rst_peak",   {16'd0, swing_peak},  32'd0);
        check("rst_dir",    {31'd0, swing_dir},   32'd0);
        check("rst_count",  {24'd0, swing_count}, 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int rand_val();
        int b;
        int m;
        int edges[9];
        edges = '{-32768, 32767, 8192, 8191, 4096, 4095, -8192, -4096, -4095};
        b = $urandom_range(0, 9);
        if (b <= 2)      m = $urandom_range(0, 4095);
        else if (b <= 4) m = $urandom_range(4096, 8191);
        else if (b <= 8) m = $urandom_range(8192, 32767);
        else return edges[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) == 1) return -m;
        else return m;
    endfunction

    initial begin
        int q[$];
        int v;
        int hold;
        rst       = 1'b1;
        angular_v = 16'sd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic swing
        q = '{0, 9000, 12000, 10000, 1000, 0};
        foreach (q[i]) run_sample(q[i]);
        check("basic_peak",  {16'd0, swing_peak},  32'd12000);
        check("basic_dir",   {31'd0, swing_dir},   32'd0);
        check("basic_count", {24'd0, swing_count}, 32'd1);

        // Negative direction with saturation
        q = '{0, 0, -8192, -32768, -9000, 0, 0};
        foreach (q[i]) run_sample(q[i]);
        check("neg_peak", {16'd0, swing_peak}, 32'd32767);
        check("neg_dir",  {31'd0, swing_dir},  32'd1);

        // Glitch rejection
        q = '{0, 0, 9000, 9000, 100, 0};
        foreach (q[i]) run_sample(q[i]);
        check("glitch_count", {24'd0, swing_count}, 32'd2);

        // Hysteresis, then samples ignored during cooldown
        q = '{9000, 5000, 5000, 0, 20000, 20000, 9000, 9000, 9000, 0, 0};
        foreach (q[i]) run_sample(q[i]);
        check("cool_count", {24'd0, swing_count}, 32'd4);

        // Stuck sensor: abort after MAX, then re-trigger after the cooldown
        q = '{0, 0};
        foreach (q[i]) run_sample(q[i]);
        for (int i = 0; i < 12; i++) run_sample(15000);
        q = '{0, 0, 0, 0};
        foreach (q[i]) run_sample(q[i]);
        check("stuck_count", {24'd0, swing_count}, 32'd4);

        // Reset in the middle of a candidate
        q = '{9000, 9000};
        foreach (q[i]) run_sample(q[i]);
        do_reset();
        q = '{0, 0};
        foreach (q[i]) run_sample(q[i]);

        // Randomised runs of held values with occasional resets
        for (int n = 0; n < 150; n++) begin
            v    = rand_val();
            hold = $urandom_range(1, 4);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 9) < 3) v = rand_val();
                run_sample(v);
            end
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        run_sample(0);
        run_sample(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
